pow_result_fifo: RTL and testbench

//   Output buffer directly downstream of the p**4 datapath. Captures each 32-bit

---
 rtl/pow_result_fifo.sv | 106 ++++++++++
 tb/tb_pow_result_fifo.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pow_result_fifo.sv
// rtl/pow_result_fifo.sv - FWFT result FIFO behind the p**4 datapath with sticky overflow (optional drop_cnt via POW_FIFO_DROP_CNT_EN)
module pow_result_fifo #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   level,
   output logic              overflow
`ifdef POW_FIFO_DROP_CNT_EN
   ,
   output logic [15:0]       drop_cnt
`endif
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
   logic              push, pop, drop;

   // Status flags, handshake qualification and fall-through head read
   always_comb begin
      empty     = (wr_ptr_q == rd_ptr_q);
      full      = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                  (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
      level     = wr_ptr_q - rd_ptr_q;
      out_valid = !empty;
      pop       = out_valid && out_ready;
      push      = in_valid && (!full || pop);
      drop      = in_valid && full && !pop;
      out_data  = empty ? '0 : mem_q[rd_ptr_q[ADDR_W-1:0]];
   end

   // Pointer advance; both wrap naturally modulo 2*DEPTH
   always_comb begin
      wr_ptr_d = wr_ptr_q + {{ADDR_W{1'b0}}, push};
      rd_ptr_d = rd_ptr_q + {{ADDR_W{1'b0}}, pop};
   end

   // Pointer registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage write; contents are meaningless after reset so no reset is applied
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[ADDR_W-1:0]] <= in_data;
      end
   end

`ifdef POW_FIFO_DROP_CNT_EN
   logic [15:0] drop_cnt_q, drop_cnt_d;

   // Saturating count of dropped pushes; overflow is derived from it
   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (drop && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_d = drop_cnt_q + 16'd1;
      end
      drop_cnt = drop_cnt_q;
      overflow = (drop_cnt_q != 16'd0);
   end

   // Drop counter register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         drop_cnt_q <= '0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end
`else
   logic overflow_q, overflow_d;

   // Sticky overflow flag, cleared only by reset
   always_comb begin
      overflow_d = overflow_q | drop;
      overflow   = overflow_q;
   end

   // Overflow register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= overflow_d;
      end
   end
`endif

endmodule

// File: tb/tb_pow_result_fifo.sv
// tb/tb_pow_result_fifo.sv - scoreboard bench for pow_result_fifo (DEPTH=4)
module tb_pow_result_fifo;

   localparam int DEPTH = 4;

   logic        clk;
   logic        rst;
   logic [31:0] in_data;
   logic        in_valid;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        full;
   logic        empty;
   logic [2:0]  level;
   logic        overflow;
`ifdef POW_FIFO_DROP_CNT_EN
   logic [15:0] drop_cnt;
`endif

   pow_result_fifo #(.DATA_W(32), .DEPTH(4), .ADDR_W(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .full      (full),
      .empty     (empty),
      .level     (level),
      .overflow  (overflow)
`ifdef POW_FIFO_DROP_CNT_EN
      ,
      .drop_cnt  (drop_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int          total = 0;
   int          bad   = 0;
   logic [31:0] exp_q [$];
   int          lvl   = 0;
   bit          ovf   = 0;
   int          dcnt  = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   // One clock of stimulus; the reference model is a queue plus an occupancy count
   task automatic cycle(input logic v, input logic [31:0] d, input logic r);
      bit pop_m, push_m;
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      pop_m  = r && (lvl > 0);
      push_m = v && ((lvl < DEPTH) || pop_m);
      @(posedge clk);
      if (push_m) exp_q.push_back(d);
      if (v && !push_m) begin
         ovf = 1;
         if (dcnt < 65535) dcnt++;
      end
      lvl = lvl + int'(push_m) - int'(pop_m);
      #1;
   endtask

   task automatic do_reset();
      in_valid  = 0;
      out_ready = 0;
      rst       = 0;
      lvl       = 0;
      exp_q.delete();
      ovf       = 0;
      dcnt      = 0;
      #2;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_level", level, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_empty", empty, 1);
      chk("rst_out_data", out_data, 0);
`ifdef POW_FIFO_DROP_CNT_EN
      chk("rst_drop_cnt", drop_cnt, 0);
`endif
      @(posedge clk);
      #1;
      rst = 1;
   endtask

   // Monitor: compares DUT state against the model away from the active edge
   initial begin
      forever begin
         @(negedge clk);
         chk("mon_level", level, 64'(lvl));
         chk("mon_empty", empty, 64'(lvl == 0));
         chk("mon_full", full, 64'(lvl == DEPTH));
         chk("mon_out_valid", out_valid, 64'(lvl > 0));
         chk("mon_overflow", overflow, 64'(ovf));
`ifdef POW_FIFO_DROP_CNT_EN
         chk("mon_drop_cnt", drop_cnt, 64'(dcnt));
`endif
         if (lvl == 0) begin
            chk("mon_idle_data", out_data, 0);
         end else if (out_ready) begin
            if (exp_q.size() == 0) begin
               chk("mon_scoreboard_nonempty", 0, 1);
            end else begin
               chk("mon_pop_data", out_data, exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      logic [31:0] p;
      rst       = 0;
      in_valid  = 0;
      in_data   = 0;
      out_ready = 0;
      @(posedge clk);
      #1;
      do_reset();

      // Three pushes held, then drained in order
      cycle(1, 32'd16, 0);
      cycle(1, 32'd81, 0);
      cycle(1, 32'd256, 0);
      cycle(0, 32'd0, 0);
      chk("t1_level", level, 3);
      chk("t1_head", out_data, 16);
      chk("t1_full", full, 0);
      repeat (4) cycle(0, 32'd0, 1);
      chk("t1_empty", empty, 1);

      // Five pushes into four slots: last one dropped
      cycle(1, 32'd16, 0);
      cycle(1, 32'd81, 0);
      cycle(1, 32'd256, 0);
      cycle(1, 32'd625, 0);
      chk("t2_full", full, 1);
      cycle(1, 32'd1296, 0);
      chk("t2_overflow", overflow, 1);
      repeat (5) cycle(0, $urandom, 1);

      // Simultaneous push and pop at full
      do_reset();
      cycle(1, 32'd16, 0);
      cycle(1, 32'd81, 0);
      cycle(1, 32'd256, 0);
      cycle(1, 32'd625, 0);
      cycle(1, 32'd4228250625, 1);
      chk("t3_level", level, 4);
      chk("t3_overflow", overflow, 0);
      repeat (5) cycle(0, 32'd0, 1);

      // Continuous stream, consumer always ready
      for (int i = 1; i <= 10; i++) begin
         p = 32'(i + 2);
         cycle(1, p * p * p * p, 1);
      end
      cycle(0, 32'd0, 1);

      // Mid-stream reset with level 3 and overflow set
      cycle(1, 32'd16, 0);
      cycle(1, 32'd81, 0);
      cycle(1, 32'd256, 0);
      cycle(1, 32'd625, 0);
      cycle(1, 32'd1296, 0);
      cycle(0, 32'd0, 1);
      chk("t5_pre_level", level, 3);
      do_reset();
      cycle(1, 32'd2401, 0);
      cycle(0, 32'd0, 1);

`ifdef POW_FIFO_DROP_CNT_EN
      // Three drops at full
      for (int i = 0; i < 4; i++) cycle(1, 32'(i), 0);
      for (int i = 0; i < 3; i++) cycle(1, 32'hDEAD0000 + 32'(i), 0);
      chk("t6_drop_cnt", drop_cnt, 3);
      do_reset();
`endif

      // Randomized traffic with varying producer/consumer rates
      for (int i = 0; i < 600; i++) begin
         int pv, pr;
         pv = (i < 200) ? 70 : (i < 400) ? 30 : 50;
         pr = (i < 200) ? 30 : (i < 400) ? 80 : 50;
         p  = $urandom_range(1, 255);
         cycle($urandom_range(0, 99) < pv, p * p * p * p, $urandom_range(0, 99) < pr);
      end
      repeat (6) cycle(0, $urandom, 1);
      chk("end_scoreboard_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
